// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, with a valid/ready holding register.
// The line is double-synchronized, the start bit is qualified at mid bit, and
// every data/stop bit is sampled one bit period after the previous sample.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | line idle, waiting for rx_s low
// S_START | timing half a bit to re-check the start bit (glitch reject)
// S_DATA  | sampling the 8 data bits at mid bit
// S_STOP  | sampling the stop bit; deliver byte or flag framing error
// S_BREAK | stop bit was low; wait for the line to return high
module uart_rx #(
  parameter int CLKS_PER_BIT = 5200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int H  = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] C_HALF_M1 = CW'(H - 1);
  localparam logic [CW-1:0] C_BIT_M1  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_rx_meta;
  logic          r_rx_s;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    r_bit_idx;
  logic [2:0]    w_bit_idx_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic          w_bit_tick;
  logic          w_deliver;
  logic          w_frame_bad;
  logic          w_xfer;
  logic [7:0]    r_rx_data;
  logic          r_rx_valid;
  logic          r_frame_err;
  logic          r_overrun;

  assign w_bit_tick = (r_cnt == C_BIT_M1);
  assign w_xfer     = r_rx_valid & rx_ready;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // FSM state register together with its bit timer, bit index and shifter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  // Next-state logic, bit timing and the deliver / framing-error strobes.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_deliver     = 1'b0;
    w_frame_bad   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!r_rx_s) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (r_cnt == C_HALF_M1) begin
          w_cnt_nxt     = '0;
          w_bit_idx_nxt = 3'd0;
          // A line that is high again at mid start bit was only a glitch.
          w_state_nxt   = r_rx_s ? S_IDLE : S_DATA;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (w_bit_tick) begin
          w_cnt_nxt              = '0;
          w_shift_nxt[r_bit_idx] = r_rx_s;
          w_bit_idx_nxt          = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_STOP: begin
        if (w_bit_tick) begin
          w_cnt_nxt = '0;
          // Leave in mid stop bit so a back-to-back start edge is not missed.
          if (r_rx_s) begin
            w_deliver   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_frame_bad = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_BREAK: begin
        w_cnt_nxt = '0;
        if (r_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Holding register plus one-cycle framing-error and overrun pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_bad;
      r_overrun   <= 1'b0;
      if (w_deliver) begin
        // A byte consumed on this very cycle frees the slot for the new one.
        if (!r_rx_valid || rx_ready) begin
          r_rx_data  <= r_shift;
          r_rx_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_xfer) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into a CLKS_PER_BIT=16 receiver checked every
// cycle against a frame-level model, plus one default-rate frame (0xAD).
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int CPB   = 16;
  localparam int H     = CPB / 2;
  localparam int CPB_D = 5200;
  localparam int H_D   = CPB_D / 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  logic       rx_d;
  logic       rx_ready_d;
  logic [7:0] rx_data_d;
  logic       rx_valid_d;
  logic       frame_err_d;
  logic       overrun_d;
  logic       busy_d;

  uart_rx #(.CLKS_PER_BIT(CPB)) u_dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  uart_rx u_dut_def (
    .clk(clk), .rst(rst), .rx(rx_d), .rx_data(rx_data_d), .rx_valid(rx_valid_d),
    .rx_ready(rx_ready_d), .frame_err(frame_err_d), .overrun(overrun_d), .busy(busy_d)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Frame-level model: each driven frame resolves at one known edge (its
  // stop-bit sample) into either a good byte or a framing error.
  typedef struct {
    int         at;
    bit         good;
    logic [7:0] d;
  } ev_t;
  ev_t ev_q[$];

  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic       m_fe    = 1'b0;
  logic       m_ov    = 1'b0;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    m_fe <= 1'b0;
    m_ov <= 1'b0;
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= 8'h00;
      ev_q.delete();
    end else if (ev_q.size() > 0 && ev_q[0].at == cyc + 1 && ev_q[0].good) begin
      if (!m_valid || rx_ready) begin
        m_valid <= 1'b1;
        m_data  <= ev_q[0].d;
      end else begin
        m_ov <= 1'b1;
      end
      ev_q.pop_front();
    end else begin
      if (ev_q.size() > 0 && ev_q[0].at == cyc + 1) begin
        m_fe <= 1'b1;
        ev_q.pop_front();
      end
      if (m_valid && rx_ready) m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst rx_valid", rx_valid, 0);
      chk("rst rx_data", rx_data, 0);
      chk("rst frame_err", frame_err, 0);
      chk("rst overrun", overrun, 0);
      chk("rst busy", busy, 0);
    end else begin
      chk("rx_valid", rx_valid, m_valid);
      if (m_valid) chk("rx_data", rx_data, m_data);
      chk("frame_err", frame_err, m_fe);
      chk("overrun", overrun, m_ov);
    end
  end

  // Event tallies used by the literal per-scenario expectations.
  int         n_fe = 0;
  int         n_ov = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] got_q[$];

  always @(negedge clk) begin
    prev_valid <= rx_valid;
    if (rx_valid && !prev_valid) got_q.push_back(rx_data);
    if (frame_err) n_fe <= n_fe + 1;
    if (overrun) n_ov <= n_ov + 1;
  end

  // Called on a negedge; start bit is first sampled by the DUT at the next posedge.
  task automatic send_frame(input logic [7:0] b, input logic stop_b);
    ev_t e;
    e.at   = cyc + 3 + H + 9 * CPB;
    e.good = stop_b;
    e.d    = b;
    ev_q.push_back(e);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_b;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  logic [7:0] b2b [4];
  logic [7:0] ad_bits;
  int s0, fe0, ov0, t0, d_at, waited;
  bit seen;

  initial begin
    rst = 1'b0; rx = 1'b1; rx_ready = 1'b0; rx_d = 1'b1; rx_ready_d = 1'b0;
    b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h55; b2b[3] = 8'hA5;
    ad_bits = 8'b1010_1101;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset def rx_valid", rx_valid_d, 0);
    chk("reset def busy", busy_d, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle busy", busy, 0);

    // Back-to-back, consumer always ready.
    rx_ready = 1'b1;
    s0 = got_q.size(); fe0 = n_fe; ov0 = n_ov;
    for (int i = 0; i < 4; i++) send_frame(b2b[i], 1'b1);
    repeat (2 * CPB) @(negedge clk);
    chk("b2b count", got_q.size() - s0, 4);
    for (int i = 0; i < 4; i++)
      if (got_q.size() > s0 + i) chk("b2b data", got_q[s0 + i], b2b[i]);
    chk("b2b frame_err count", n_fe - fe0, 0);
    chk("b2b overrun count", n_ov - ov0, 0);

    // Overrun: second byte dropped while the first is held.
    rx_ready = 1'b0;
    ov0 = n_ov;
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    chk("overrun kept data", rx_data, 8'h12);
    chk("overrun kept valid", rx_valid, 1);
    chk("overrun count", n_ov - ov0, 1);

    // Same, but consumed on exactly the delivery cycle.
    ov0 = n_ov;
    d_at = cyc + 3 + H + 9 * CPB;
    fork
      send_frame(8'h34, 1'b1);
      begin
        while (cyc < d_at - 1) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    repeat (2 * CPB) @(negedge clk);
    chk("same-cycle consume data", rx_data, 8'h34);
    chk("same-cycle consume overrun", n_ov - ov0, 0);

    // Reset in the middle of a data bit with a byte still held.
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = ad_bits[i];
      repeat (CPB) @(negedge clk);
    end
    chk("pre-reset busy", busy, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async reset rx_valid", rx_valid, 0);
    chk("async reset rx_data", rx_data, 8'h00);
    chk("async reset busy", busy, 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rx_ready = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    s0 = got_q.size();
    send_frame(8'h3C, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    chk("post-reset count", got_q.size() - s0, 1);
    if (got_q.size() > 0) chk("post-reset data", got_q[$], 8'h3C);

    // Stop bit low.
    s0 = got_q.size(); fe0 = n_fe;
    send_frame(8'hC3, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    chk("stop-low frame_err count", n_fe - fe0, 1);
    chk("stop-low no valid", got_q.size() - s0, 0);

    // Break: line low for 40 bit times, then a good frame.
    begin
      ev_t e;
      e.at = cyc + 3 + H + 9 * CPB; e.good = 1'b0; e.d = 8'h00;
      ev_q.push_back(e);
    end
    s0 = got_q.size(); fe0 = n_fe;
    rx = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("break frame_err count", n_fe - fe0, 1);
    send_frame(8'h7E, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    chk("after-break count", got_q.size() - s0, 1);
    if (got_q.size() > 0) chk("after-break data", got_q[$], 8'h7E);

    // Three-cycle glitch.
    s0 = got_q.size(); fe0 = n_fe;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    chk("glitch busy before latency", busy, 0);
    @(negedge clk);
    chk("glitch busy latency", busy, 1);
    rx = 1'b1;
    repeat (7) @(negedge clk);
    chk("glitch still in start", busy, 1);
    @(negedge clk);
    chk("glitch busy released", busy, 0);
    repeat (2 * CPB) @(negedge clk);
    chk("glitch no valid", got_q.size() - s0, 0);
    chk("glitch no frame_err", n_fe - fe0, 0);

    // Default rate: 0xAD on the second instance.
    t0 = cyc;
    rx_d = 1'b0;
    repeat (CPB_D) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_d = ad_bits[i];
      repeat (CPB_D) @(negedge clk);
    end
    rx_d = 1'b1;
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < 2 * CPB_D) begin
      if (rx_valid_d) seen = 1'b1;
      else begin
        @(negedge clk);
        waited++;
      end
    end
    chk("default frame seen", seen, 1);
    if (seen) begin
      chk("default latency", cyc - t0, 3 + H_D + 9 * CPB_D);
      chk("default data", rx_data_d, 8'hAD);
      chk("default frame_err", frame_err_d, 0);
      rx_ready_d = 1'b1;
      @(negedge clk);
      rx_ready_d = 1'b0;
      chk("default consume", rx_valid_d, 0);
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
